// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared constants and the hex-to-seven-segment decoder for the
//            multiplexed display driver.
// Contents : NUM_DIGITS, SEG_OFF, AN_OFF, hex_to_seg()
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [6:0] SEG_OFF    = 7'h7F;  // all cathodes released (active low)
  localparam logic [7:0] AN_OFF     = 8'hFF;  // all anodes released (active low)

  // Active-low segment pattern, bit0 = segment a ... bit6 = segment g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] i_nib);
    logic [6:0] w_seg;
    case (i_nib)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      default: w_seg = 7'h0E;
    endcase
    return w_seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Purpose  : Free-running modulo-DIV counter with a terminal-count pulse.
// Ports    : i_clk    - clock
//            i_rst_n  - asynchronous active-low reset
//            o_count  - current count, 0..DIV-1
//            o_wrap   - high during the cycle the count equals DIV-1
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen #(
  parameter  int DIV = 2,
  localparam int W   = $clog2(DIV)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  logic [W-1:0] r_count;
  logic         w_wrap;

  assign w_wrap = (r_count == W'(DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (w_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;
  assign o_wrap  = w_wrap;

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Time-multiplexed driver for an 8-digit common-anode seven-segment
//            display. Inputs are captured once per frame so a digit never
//            tears mid-scan; each digit slot opens with a blanking window to
//            stop the previous digit ghosting onto the next anode.
// Ports    : clk_i    - system clock
//            rst_ni   - asynchronous active-low reset
//            data_i   - eight hex nibbles, nibble k drives digit k
//            en_i     - per-digit enable
//            dp_i     - per-digit decimal point
//            blink_i  - per-digit blink enable
//            seg_o    - cathodes CA..CG, active low
//            dp_o     - decimal-point cathode, active low
//            an_o     - anodes, active low, an_o[k] selects digit k
//            frame_o  - one-cycle pulse marking each snapshot load
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] data_i,
  input  logic [7:0]  en_i,
  input  logic [7:0]  dp_i,
  input  logic [7:0]  blink_i,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [7:0]  an_o,
  output logic        frame_o
);

  localparam int SLOT_W  = $clog2(REFRESH_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  logic [SLOT_W-1:0]  w_slot_cnt;
  logic               w_slot_wrap;
  logic [BLINK_W-1:0] w_blink_cnt_unused;
  logic               w_blink_wrap;

  tick_gen #(.DIV(REFRESH_DIV)) u_slot_tick (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .o_count (w_slot_cnt),
    .o_wrap  (w_slot_wrap)
  );

  tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .o_count (w_blink_cnt_unused),
    .o_wrap  (w_blink_wrap)
  );

  logic [2:0]  r_idx;
  logic        r_phase;
  logic [31:0] r_data_snap;
  logic [7:0]  r_en_snap;
  logic [7:0]  r_dp_snap;
  logic [7:0]  r_blink_snap;

  // Frame boundary: last cycle of the last digit slot.
  logic w_frame;
  assign w_frame = w_slot_wrap && (r_idx == 3'(NUM_DIGITS - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx        <= '0;
      r_phase      <= 1'b0;
      r_data_snap  <= '0;
      r_en_snap    <= '0;
      r_dp_snap    <= '0;
      r_blink_snap <= '0;
    end else begin
      if (w_slot_wrap) begin
        r_idx <= r_idx + 3'd1;
      end
      if (w_blink_wrap) begin
        r_phase <= ~r_phase;
      end
      if (w_frame) begin
        r_data_snap  <= data_i;
        r_en_snap    <= en_i;
        r_dp_snap    <= dp_i;
        r_blink_snap <= blink_i;
      end
    end
  end

  // Current digit selection, driven only by registered state.
  logic [3:0] w_nib;
  logic       w_lit;

  assign w_nib = r_data_snap[{r_idx, 2'b00} +: 4];
  assign w_lit = (w_slot_cnt >= SLOT_W'(BLANK_CYC))
              && r_en_snap[r_idx]
              && !(r_blink_snap[r_idx] && r_phase);

  // Output stage registers everything so the pins never glitch while the
  // slot/index state changes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      an_o    <= AN_OFF;
      seg_o   <= SEG_OFF;
      dp_o    <= 1'b1;
      frame_o <= 1'b0;
    end else begin
      frame_o <= w_frame;
      if (w_lit) begin
        an_o  <= ~(8'h01 << r_idx);
        seg_o <= hex_to_seg(w_nib);
        dp_o  <= ~r_dp_snap[r_idx];
      end else begin
        an_o  <= AN_OFF;
        seg_o <= SEG_OFF;
        dp_o  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Directed self-checking bench for seg7_scan_driver with small
//            divisors (8-cycle slots, 2-cycle blanking, 64-cycle blink phase).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int BD = 64;
  localparam int FRAME = RD * 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] data_i;
  logic [7:0]  en_i, dp_i, blink_i;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [7:0]  an_o;
  logic        frame_o;

  seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYC(BC), .BLINK_DIV(BD)) u_dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .data_i  (data_i),
    .en_i    (en_i),
    .dp_i    (dp_i),
    .blink_i (blink_i),
    .seg_o   (seg_o),
    .dp_o    (dp_o),
    .an_o    (an_o),
    .frame_o (frame_o)
  );

  always #5 clk_i = ~clk_i;

  // Hand-written decode table (active low, bit0 = a).
  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_chk = 0;
  int n_err = 0;
  int e = 0;          // rising edges since reset release
  int last_fr = -1;   // edge number of the previous frame_o pulse

  // Bench's view of the DUT snapshot registers.
  logic [31:0] s_data;
  logic [7:0]  s_en, s_dp, s_blink;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and compare every pin against the expected value
  // derived from the edge count and the snapshot in force before that edge.
  task automatic step();
    logic [31:0] u_data, c_data;
    logic [7:0]  u_en, u_dp, u_blink, c_en, c_dp, c_blink;
    logic [7:0]  x_an;
    logic [6:0]  x_seg;
    logic        x_dp, lit;
    int          s, cnt, idx, ph;
    u_data = s_data; u_en = s_en; u_dp = s_dp; u_blink = s_blink;
    c_data = data_i; c_en = en_i; c_dp = dp_i; c_blink = blink_i;
    @(posedge clk_i);
    #1;
    e++;
    if (e % FRAME == 0) begin
      s_data = c_data; s_en = c_en; s_dp = c_dp; s_blink = c_blink;
    end
    s   = e - 1;
    cnt = s % RD;
    idx = (s / RD) % 8;
    ph  = (s / BD) % 2;
    lit = (cnt >= BC) && u_en[idx] && !(u_blink[idx] && (ph == 1));
    x_an  = lit ? ~(8'h01 << idx) : 8'hFF;
    x_seg = lit ? seg_tbl[u_data[idx*4 +: 4]] : 7'h7F;
    x_dp  = lit ? ~u_dp[idx] : 1'b1;
    chk("an_o", 32'(an_o), 32'(x_an));
    chk("seg_o", 32'(seg_o), 32'(x_seg));
    chk("dp_o", 32'(dp_o), 32'(x_dp));
    chk("frame_o", 32'(frame_o), 32'(s % FRAME == FRAME - 1));
    if (frame_o) begin
      if (last_fr >= 0) chk("frame_gap", 32'(e - last_fr), 32'(FRAME));
      last_fr = e;
    end
  endtask

  task automatic run_to(input int target);
    while (e < target) step();
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) chk("one_anode", 32'($countones(~an_o) <= 1), 32'd1);
  end

  initial begin
    data_i = 32'h76543210; en_i = 8'hFF; dp_i = 8'h00; blink_i = 8'h00;
    s_data = '0; s_en = '0; s_dp = '0; s_blink = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_an", 32'(an_o), 32'hFF);
    chk("rst_seg", 32'(seg_o), 32'h7F);
    chk("rst_dp", 32'(dp_o), 32'd1);
    chk("rst_frame", 32'(frame_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Dark first frame, then digits 0..7.
    run_to(64);  chk("first_frame", 32'(frame_o), 32'd1);
    run_to(67);  chk("d0_an", 32'(an_o), 32'hFE); chk("d0_seg", 32'(seg_o), 32'h40);
    run_to(75);  chk("d1_an", 32'(an_o), 32'hFD); chk("d1_seg", 32'(seg_o), 32'h79);

    // Mid-frame data change is held off until the next boundary.
    run_to(140); data_i = 32'hFFFFFFFF;
    run_to(147); chk("old_digit", 32'(seg_o), 32'h24);
    run_to(195); chk("new_digit", 32'(seg_o), 32'h0E);

    // Enable, decimal point and blink masks.
    data_i = 32'h76543210; en_i = 8'h05; dp_i = 8'h04; blink_i = 8'h01;
    run_to(259); chk("blink_vis", 32'(an_o), 32'hFE);
    run_to(276); chk("slot2_an", 32'(an_o), 32'hFB); chk("slot2_dp", 32'(dp_o), 32'd0);
    run_to(323); chk("blink_dark", 32'(an_o), 32'hFF);
    run_to(342); chk("slot2_b1", 32'(an_o), 32'hFB);
    run_to(704);
    run_to(726); chk("pre_rst_an", 32'(an_o), 32'hFB);

    // Asynchronous reset with an anode active.
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_an", 32'(an_o), 32'hFF);
    chk("arst_seg", 32'(seg_o), 32'h7F);
    chk("arst_dp", 32'(dp_o), 32'd1);
    chk("arst_frame", 32'(frame_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    e = 0; last_fr = -1;
    s_data = '0; s_en = '0; s_dp = '0; s_blink = '0;
    run_to(22);  chk("dark_after_rst", 32'(an_o), 32'hFF);
    run_to(64);  chk("rst_frame_pos", 32'(frame_o), 32'd1);
    run_to(86);  chk("idx_restart", 32'(an_o), 32'hFB);
    run_to(131); chk("d0_phase0", 32'(an_o), 32'hFE);
    run_to(192);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
